// File: rtl/riscv_mc_control.sv
// Multicycle RISC-V control unit: Moore sequencer for lw/sw/R/I/beq/jal
// plus the ALU decoder. Outputs are combinational from the state register.
module riscv_mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic [3:0] state
);

  localparam int unsigned OP_W = 7;
  localparam int unsigned ST_W = 4;

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

  typedef enum logic [ST_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t      state_q;
  state_t      state_n;
  state_t      state_eff;
  logic [1:0]  alu_op;
  logic        branch;
  logic        pc_update;
  logic        ir_write_s;
  logic        mem_write_s;
  logic        reg_write_s;

  // State register; reset returns to FETCH even mid-instruction.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_n;
  end

  // Next-state sequencing; unused codes fall back to FETCH.
  always_comb begin
    state_n = FETCH;
    case (state_q)
      FETCH:    state_n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_R:         state_n = EXECUTER;
          OP_I:         state_n = EXECUTEI;
          OP_BEQ:       state_n = BEQ;
          OP_JAL:       state_n = JAL;
          default:      state_n = FETCH;
        endcase
      end
      MEMADR:   state_n = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_n = MEMWB;
      MEMWB:    state_n = FETCH;
      MEMWRITE: state_n = FETCH;
      EXECUTER: state_n = ALUWB;
      EXECUTEI: state_n = ALUWB;
      ALUWB:    state_n = FETCH;
      BEQ:      state_n = FETCH;
      JAL:      state_n = ALUWB;
      default:  state_n = FETCH;
    endcase
  end

  // While reset is high the outputs present FETCH decoding with writes masked.
  assign state_eff = reset ? FETCH : state_q;
  assign state     = ST_W'(state_eff);

  // Moore output decode per state.
  always_comb begin
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op      = 2'b00;
    branch      = 1'b0;
    pc_update   = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    case (state_eff)
      FETCH: begin
        ir_write_s = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pc_update  = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      ALUWB: reg_write_s = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables, with the taken-branch path folded into PCWrite.
  assign PCWrite  = ~reset & (pc_update | (branch & zero));
  assign IRWrite  = ~reset & ir_write_s;
  assign MemWrite = ~reset & mem_write_s;
  assign RegWrite = ~reset & reg_write_s;

  // Immediate format from opcode, independent of state.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // ALU decoder; subtract only for R-type with funct7b5 set.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_riscv_mc_control.sv
// Directed bench for riscv_mc_control with a queue-based scoreboard.
module tb_riscv_mc_control;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic       rw;
    logic [2:0] alu;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  riscv_mc_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] imm_of(logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // Expected outputs for a state, from the per-state output table.
  function automatic exp_t mk(int unsigned s, logic pcw, logic [2:0] alu, logic [6:0] o);
    exp_t e;
    e     = '0;
    e.st  = 4'(s);
    e.pcw = pcw;
    e.alu = alu;
    e.imm = imm_of(o);
    case (s)
      0:  begin e.irw = 1'b1; e.sb = 2'b10; e.rs = 2'b10; end
      1:  begin e.sa = 2'b01; e.sb = 2'b01; end
      2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      3:  e.adr = 1'b1;
      4:  begin e.rs = 2'b01; e.rw = 1'b1; end
      5:  begin e.adr = 1'b1; e.mw = 1'b1; end
      6:  e.sa = 2'b10;
      7:  begin e.sa = 2'b10; e.sb = 2'b01; end
      8:  e.rw = 1'b1;
      9:  e.sa = 2'b10;
      10: begin e.sa = 2'b01; e.sb = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t mk_reset(logic [6:0] o);
    exp_t e;
    e     = mk(0, 1'b0, 3'b000, o);
    e.irw = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input exp_t e);
    exp_t got;
    exp_t want;
    exp_q.push_back(e);
    #1;
    got = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ImmSrc, RegWrite, ALUControl};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, got);
    end else begin
      want = exp_q.pop_front();
      assert (got === want) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h (st %0d vs %0d)",
               tag, got, want, got.st, want.st);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input int unsigned s, input logic pcw, input logic [2:0] alu);
    chk(tag, mk(s, pcw, alu, op));
    tick();
  endtask

  task automatic set_ins(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b1;
    zero     = 1'b0;
    set_ins(7'b0000000, 3'b000, 1'b0);
    tick();

    chk("reset0", mk_reset(op)); tick();
    chk("reset1", mk_reset(op)); tick();
    reset = 1'b0;

    // lw: 0,1,2,3,4
    set_ins(7'b0000011, 3'b010, 1'b0);
    zero = 1'b1;
    cyc("lw_f", 0, 1'b1, 3'b000);
    cyc("lw_d", 1, 1'b0, 3'b000);
    cyc("lw_a", 2, 1'b0, 3'b000);
    cyc("lw_r", 3, 1'b0, 3'b000);
    cyc("lw_w", 4, 1'b0, 3'b000);

    // sub then add
    set_ins(7'b0110011, 3'b000, 1'b1);
    cyc("sub_f", 0, 1'b1, 3'b000);
    cyc("sub_d", 1, 1'b0, 3'b000);
    cyc("sub_x", 6, 1'b0, 3'b001);
    cyc("sub_w", 8, 1'b0, 3'b000);
    set_ins(7'b0110011, 3'b000, 1'b0);
    cyc("add_f", 0, 1'b1, 3'b000);
    cyc("add_d", 1, 1'b0, 3'b000);
    cyc("add_x", 6, 1'b0, 3'b000);
    cyc("add_w", 8, 1'b0, 3'b000);

    // I-type: addi (funct7b5=1), slti, ori, andi
    set_ins(7'b0010011, 3'b000, 1'b1);
    cyc("addi_f", 0, 1'b1, 3'b000);
    cyc("addi_d", 1, 1'b0, 3'b000);
    cyc("addi_x", 7, 1'b0, 3'b000);
    cyc("addi_w", 8, 1'b0, 3'b000);
    set_ins(7'b0010011, 3'b010, 1'b0);
    cyc("slti_f", 0, 1'b1, 3'b000);
    cyc("slti_d", 1, 1'b0, 3'b000);
    cyc("slti_x", 7, 1'b0, 3'b101);
    cyc("slti_w", 8, 1'b0, 3'b000);
    set_ins(7'b0010011, 3'b110, 1'b0);
    cyc("ori_f", 0, 1'b1, 3'b000);
    cyc("ori_d", 1, 1'b0, 3'b000);
    cyc("ori_x", 7, 1'b0, 3'b011);
    cyc("ori_w", 8, 1'b0, 3'b000);
    set_ins(7'b0010011, 3'b111, 1'b0);
    cyc("andi_f", 0, 1'b1, 3'b000);
    cyc("andi_d", 1, 1'b0, 3'b000);
    cyc("andi_x", 7, 1'b0, 3'b010);
    cyc("andi_w", 8, 1'b0, 3'b000);

    // beq taken then not taken
    set_ins(7'b1100011, 3'b000, 1'b0);
    zero = 1'b1;
    cyc("beqt_f", 0, 1'b1, 3'b000);
    cyc("beqt_d", 1, 1'b0, 3'b000);
    cyc("beqt_b", 9, 1'b1, 3'b001);
    zero = 1'b0;
    cyc("beqn_f", 0, 1'b1, 3'b000);
    cyc("beqn_d", 1, 1'b0, 3'b000);
    cyc("beqn_b", 9, 1'b0, 3'b001);

    // jal: 0,1,10,8
    set_ins(7'b1101111, 3'b000, 1'b0);
    zero = 1'b1;
    cyc("jal_f", 0, 1'b1, 3'b000);
    cyc("jal_d", 1, 1'b0, 3'b000);
    cyc("jal_j", 10, 1'b1, 3'b000);
    cyc("jal_w", 8, 1'b0, 3'b000);

    // sw: 0,1,2,5
    set_ins(7'b0100011, 3'b010, 1'b0);
    cyc("sw_f", 0, 1'b1, 3'b000);
    cyc("sw_d", 1, 1'b0, 3'b000);
    cyc("sw_a", 2, 1'b0, 3'b000);
    cyc("sw_m", 5, 1'b0, 3'b000);

    // unsupported opcode: 0,1 then back to 0
    set_ins(7'b1111111, 3'b000, 1'b1);
    cyc("bad_f", 0, 1'b1, 3'b000);
    cyc("bad_d", 1, 1'b0, 3'b000);

    // reset asserted during MEMWRITE
    set_ins(7'b0100011, 3'b010, 1'b0);
    cyc("swr_f", 0, 1'b1, 3'b000);
    cyc("swr_d", 1, 1'b0, 3'b000);
    cyc("swr_a", 2, 1'b0, 3'b000);
    chk("swr_m", mk(5, 1'b0, 3'b000, op));
    reset = 1'b1;
    chk("swr_rst", mk_reset(op));
    tick();
    chk("swr_rst2", mk_reset(op));
    reset = 1'b0;
    cyc("swr_post", 0, 1'b1, 3'b000);
    cyc("swr_post_d", 1, 1'b0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
